// File: rtl/aes_enc_arbiter.sv
// aes_enc_arbiter: round-robin front end sharing one iterative AES-128
// core between N_REQ requesters, with per-request timeout and tagged reply.
module aes_enc_arbiter #(
    parameter int N_REQ   = 2,
    parameter int ID_W    = 1,
    parameter int TIMEOUT = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [N_REQ*128-1:0] req_pt,
    input  logic [N_REQ*128-1:0] req_key,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [ID_W-1:0]      resp_id,
    output logic [127:0]         resp_ct,
    output logic                 resp_err,
    output logic                 core_encrypt,
    output logic [127:0]         core_pt,
    output logic [127:0]         core_key,
    input  logic                 core_done,
    input  logic [127:0]         core_dout
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state, state_nx;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  gnt_idx, hi_idx, lo_idx;
    logic             hi_found, lo_found;
    logic [127:0]     sel_pt, sel_key;
    logic [CNT_W-1:0] cnt;
    logic             timed_out;
    logic             accept;

    // hi_* is the lowest valid index at/above rr_ptr, lo_* the lowest overall (wrap)
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req_valid[j]) begin
                if (ID_W'(j) >= rr_ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(j);
                end
                lo_found = 1'b1;
                lo_idx   = ID_W'(j);
            end
        end
        gnt_idx = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        sel_pt  = '0;
        sel_key = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (ID_W'(j) == gnt_idx) begin
                sel_pt  = req_pt[j*128 +: 128];
                sel_key = req_key[j*128 +: 128];
            end
        end
    end

    assign timed_out = (cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_nx     = state;
        req_ready    = '0;
        resp_valid   = 1'b0;
        core_encrypt = 1'b0;
        accept       = 1'b0;
        unique case (state)
            IDLE: begin
                if (lo_found && !reset) begin
                    accept   = 1'b1;
                    state_nx = ISSUE;
                    for (int j = 0; j < N_REQ; j++) begin
                        req_ready[j] = (ID_W'(j) == gnt_idx);
                    end
                end
            end
            ISSUE: begin
                core_encrypt = 1'b1;
                state_nx     = WAIT;
            end
            WAIT: begin
                if (core_done || timed_out) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr   <= '0;
            core_pt  <= '0;
            core_key <= '0;
            resp_id  <= '0;
            resp_ct  <= '0;
            resp_err <= 1'b0;
            cnt      <= '0;
        end else begin
            if (accept) begin
                core_pt  <= sel_pt;
                core_key <= sel_key;
                resp_id  <= gnt_idx;
                rr_ptr   <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0
                                                          : gnt_idx + ID_W'(1);
            end
            if (state == ISSUE) begin
                cnt <= '0;
            end
            // done takes priority over an expiring counter
            if (state == WAIT) begin
                if (core_done) begin
                    resp_ct  <= core_dout;
                    resp_err <= 1'b0;
                end else if (timed_out) begin
                    resp_ct  <= '0;
                    resp_err <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_enc_arbiter.sv
// tb_aes_enc_arbiter: scenario tasks plus a behavioural core model and
// a round-robin reference for the AES encryption arbiter.
module tb_aes_enc_arbiter;

    localparam int N  = 3;
    localparam int IW = 2;
    localparam int TO = 16;

    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic           clock;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*128-1:0] req_pt;
    logic [N*128-1:0] req_key;
    logic           resp_valid;
    logic           resp_ready;
    logic [IW-1:0]  resp_id;
    logic [127:0]   resp_ct;
    logic           resp_err;
    logic           core_encrypt;
    logic [127:0]   core_pt;
    logic [127:0]   core_key;
    logic           core_done;
    logic [127:0]   core_dout;

    aes_enc_arbiter #(.N_REQ(N), .ID_W(IW), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_pt(req_pt), .req_key(req_key),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_ct(resp_ct), .resp_err(resp_err),
        .core_encrypt(core_encrypt), .core_pt(core_pt), .core_key(core_key),
        .core_done(core_done), .core_dout(core_dout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_ptr = 0;
    logic [127:0] pts [N];
    logic [127:0] keys [N];

    // reference core: FIPS-197 vector known, otherwise an arbitrary mix
    function automatic logic [127:0] core_fn(input logic [127:0] pt,
                                             input logic [127:0] key);
        if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
        return {pt[63:0], pt[127:64]} ^ key ^ 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
    endfunction

    function automatic int exp_grant(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (p + k) % N;
            if (m[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // core model
    int           core_lat = 12;
    bit           core_hang = 0;
    bit           m_busy = 0;
    int           m_cnt = 0;
    logic [127:0] m_pt, m_key;
    int           enc_pulses = 0;
    int           pt_changes = 0;

    always @(posedge clock) begin
        core_done <= 1'b0;
        core_dout <= rnd128();
        if (core_encrypt) begin
            m_busy     <= 1'b1;
            m_cnt      <= 1;
            m_pt       <= core_pt;
            m_key      <= core_key;
            enc_pulses <= enc_pulses + 1;
        end else if (m_busy) begin
            if (core_pt !== m_pt || core_key !== m_key) pt_changes <= pt_changes + 1;
            if (!core_hang && m_cnt >= core_lat) begin
                core_done <= 1'b1;
                core_dout <= core_fn(m_pt, m_key);
                m_busy    <= 1'b0;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // monitor
    int   cyc_n = 0, enc_n = 0, resp_n = 0, resp_cnt = 0;
    int   multi_rdy = 0, rdy_in_resp = 0;
    logic prev_rv = 1'b0;

    always @(negedge clock) begin
        cyc_n++;
        if (core_encrypt === 1'b1) enc_n = cyc_n;
        if (resp_valid === 1'b1 && !prev_rv) begin
            resp_n = cyc_n;
            resp_cnt++;
        end
        prev_rv = (resp_valid === 1'b1);
        if ($countones(req_ready) > 1) multi_rdy++;
        if (resp_valid === 1'b1 && |req_ready) rdy_in_resp++;
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic apply_ops();
        for (int i = 0; i < N; i++) begin
            req_pt[i*128 +: 128]  = pts[i];
            req_key[i*128 +: 128] = keys[i];
        end
    endtask

    task automatic wait_grant(output logic [N-1:0] rdy, output bit to);
        to  = 1'b1;
        rdy = '0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (|req_ready) begin
                rdy = req_ready;
                to  = 1'b0;
                break;
            end
            @(negedge clock);
        end
    endtask

    task automatic wait_resp(output bit to);
        to = 1'b1;
        for (int c = 0; c < 200; c++) begin
            if (resp_valid === 1'b1) begin
                to = 1'b0;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = '1;
        tick();
        tick();
        n_cmp++;
        if (req_ready !== '0) begin
            n_bad++; $display("FAIL reset_ready: got %b want 000", req_ready);
        end
        n_cmp++;
        if ({resp_valid, resp_err, core_encrypt} !== 3'b000) begin
            n_bad++; $display("FAIL reset_flags: got %b want 000", {resp_valid, resp_err, core_encrypt});
        end
        n_cmp++;
        if (resp_id !== '0 || resp_ct !== '0) begin
            n_bad++; $display("FAIL reset_resp: got id %0d ct %h want 0", resp_id, resp_ct);
        end
        n_cmp++;
        if (core_pt !== '0 || core_key !== '0) begin
            n_bad++; $display("FAIL reset_core_ops: got %h %h want 0", core_pt, core_key);
        end
        req_valid = '0;
        reset = 1'b0;
        exp_ptr = 0;
        tick();
    endtask

    task automatic test_fairness();
        logic [N-1:0] rdy;
        bit to;
        int g;
        for (int i = 0; i < N; i++) begin
            pts[i] = rnd128();
            keys[i] = rnd128();
        end
        apply_ops();
        req_valid = 3'b011;
        for (int k = 0; k < 4; k++) begin
            core_lat = $urandom_range(1, 8);
            g = exp_grant(3'b011, exp_ptr);
            wait_grant(rdy, to);
            n_cmp++;
            if (rdy !== onehot(g)) begin
                n_bad++; $display("FAIL fair_grant%0d: got %b want %b", k, rdy, onehot(g));
            end
            tick();
            if (k == 3) req_valid = '0;
            wait_resp(to);
            n_cmp++;
            if (to || resp_id !== IW'(g) || resp_ct !== core_fn(pts[g], keys[g])) begin
                n_bad++; $display("FAIL fair_resp%0d: got id %0d ct %h want id %0d ct %h",
                                  k, resp_id, resp_ct, g, core_fn(pts[g], keys[g]));
            end
            exp_ptr = (g + 1) % N;
        end
        n_cmp++;
        if (multi_rdy !== 0) begin
            n_bad++; $display("FAIL fair_onehot: got %0d multi-ready cycles want 0", multi_rdy);
        end
        tick();
    endtask

    task automatic test_single();
        logic [N-1:0] rdy;
        bit to;
        int e0;
        pts[0] = FIPS_PT;
        keys[0] = FIPS_KEY;
        apply_ops();
        core_lat = 12;
        e0 = enc_pulses;
        req_valid = 3'b001;
        wait_grant(rdy, to);
        n_cmp++;
        if (rdy !== 3'b001) begin
            n_bad++; $display("FAIL single_grant: got %b want 001", rdy);
        end
        tick();
        req_valid = '0;
        exp_ptr = 1;
        wait_resp(to);
        n_cmp++;
        if (to || resp_id !== 0 || resp_err !== 1'b0) begin
            n_bad++; $display("FAIL single_id_err: got id %0d err %b want 0 0", resp_id, resp_err);
        end
        n_cmp++;
        if (resp_ct !== FIPS_CT) begin
            n_bad++; $display("FAIL single_ct: got %h want %h", resp_ct, FIPS_CT);
        end
        n_cmp++;
        if (resp_n - enc_n !== 14) begin
            n_bad++; $display("FAIL single_latency: got %0d want 14", resp_n - enc_n);
        end
        tick();
        n_cmp++;
        if (resp_valid !== 1'b0) begin
            n_bad++; $display("FAIL single_release: got %b want 0", resp_valid);
        end
        repeat (5) tick();
        n_cmp++;
        if (enc_pulses - e0 !== 1) begin
            n_bad++; $display("FAIL single_pulses: got %0d want 1", enc_pulses - e0);
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] rdy;
        bit to;
        int hold_bad, r0;
        logic [IW-1:0] id0;
        logic [127:0] ct0;
        logic err0;
        for (int i = 0; i < N; i++) begin
            pts[i] = rnd128();
            keys[i] = rnd128();
        end
        apply_ops();
        core_lat = 6;
        resp_ready = 1'b0;
        req_valid = 3'b100;
        wait_grant(rdy, to);
        n_cmp++;
        if (rdy !== onehot(exp_grant(3'b100, exp_ptr))) begin
            n_bad++; $display("FAIL bp_grant: got %b want 100", rdy);
        end
        exp_ptr = 0;
        tick();
        req_valid = 3'b011;
        r0 = rdy_in_resp;
        wait_resp(to);
        id0 = resp_id;
        ct0 = resp_ct;
        err0 = resp_err;
        hold_bad = 0;
        repeat (20) begin
            tick();
            if (resp_valid !== 1'b1 || resp_id !== id0 || resp_ct !== ct0 || resp_err !== err0)
                hold_bad++;
        end
        n_cmp++;
        if (to || hold_bad !== 0) begin
            n_bad++; $display("FAIL bp_hold: got %0d unstable cycles (to=%0d) want 0", hold_bad, to);
        end
        n_cmp++;
        if (id0 !== 2 || ct0 !== core_fn(pts[2], keys[2]) || err0 !== 1'b0) begin
            n_bad++; $display("FAIL bp_data: got id %0d ct %h want 2 %h", id0, ct0, core_fn(pts[2], keys[2]));
        end
        n_cmp++;
        if (rdy_in_resp - r0 !== 0) begin
            n_bad++; $display("FAIL bp_no_ready: got %0d cycles want 0", rdy_in_resp - r0);
        end
        resp_ready = 1'b1;
        tick();
        n_cmp++;
        if (resp_valid !== 1'b0 || req_ready !== onehot(exp_grant(3'b011, exp_ptr))) begin
            n_bad++; $display("FAIL bp_release: got valid %b ready %b want 0 %b",
                              resp_valid, req_ready, onehot(exp_grant(3'b011, exp_ptr)));
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_timeout();
        logic [N-1:0] rdy;
        bit to;
        pts[1] = rnd128();
        keys[1] = rnd128();
        apply_ops();
        core_hang = 1'b1;
        req_valid = 3'b010;
        wait_grant(rdy, to);
        tick();
        req_valid = '0;
        exp_ptr = 2;
        wait_resp(to);
        n_cmp++;
        if (to || resp_err !== 1'b1 || resp_ct !== '0 || resp_id !== 1) begin
            n_bad++; $display("FAIL timeout_resp: got err %b ct %h id %0d want 1 0 1", resp_err, resp_ct, resp_id);
        end
        n_cmp++;
        if (resp_n - enc_n !== TO + 1) begin
            n_bad++; $display("FAIL timeout_latency: got %0d want %0d", resp_n - enc_n, TO + 1);
        end
        core_hang = 1'b0;
        core_lat = 5;
        tick();
        pts[0] = rnd128();
        keys[0] = rnd128();
        apply_ops();
        req_valid = 3'b001;
        wait_grant(rdy, to);
        tick();
        req_valid = '0;
        exp_ptr = 1;
        wait_resp(to);
        n_cmp++;
        if (to || resp_err !== 1'b0 || resp_ct !== core_fn(pts[0], keys[0])) begin
            n_bad++; $display("FAIL timeout_recover: got err %b ct %h want 0 %h", resp_err, resp_ct, core_fn(pts[0], keys[0]));
        end
        tick();
    endtask

    task automatic test_done_boundary();
        logic [N-1:0] rdy;
        bit to;
        logic exp_err;
        for (int lat = TO - 1; lat <= TO; lat++) begin
            pts[1] = rnd128();
            keys[1] = rnd128();
            apply_ops();
            core_lat = lat;
            exp_err = (lat >= TO);
            req_valid = 3'b010;
            wait_grant(rdy, to);
            tick();
            req_valid = '0;
            exp_ptr = 2;
            wait_resp(to);
            n_cmp++;
            if (to || resp_err !== exp_err ||
                resp_ct !== (exp_err ? 128'h0 : core_fn(pts[1], keys[1]))) begin
                n_bad++; $display("FAIL boundary_lat%0d: got err %b ct %h want err %b", lat, resp_err, resp_ct, exp_err);
            end
            n_cmp++;
            if (resp_n - enc_n !== TO + 1) begin
                n_bad++; $display("FAIL boundary_time%0d: got %0d want %0d", lat, resp_n - enc_n, TO + 1);
            end
            tick();
        end
    endtask

    task automatic test_stability();
        logic [N-1:0] rdy;
        bit to;
        logic [127:0] a_pt, a_key;
        int base;
        a_pt = rnd128();
        a_key = rnd128();
        pts[2] = a_pt;
        keys[2] = a_key;
        apply_ops();
        core_lat = 10;
        base = pt_changes;
        req_valid = 3'b100;
        wait_grant(rdy, to);
        n_cmp++;
        if (rdy !== onehot(exp_grant(3'b100, exp_ptr))) begin
            n_bad++; $display("FAIL stab_grant: got %b want 100", rdy);
        end
        tick();
        req_valid = '0;
        exp_ptr = 0;
        pts[2] = rnd128();
        keys[2] = rnd128();
        apply_ops();
        repeat (4) tick();
        n_cmp++;
        if (core_pt !== a_pt || core_key !== a_key) begin
            n_bad++; $display("FAIL stab_core_ops: got %h want %h", core_pt, a_pt);
        end
        wait_resp(to);
        n_cmp++;
        if (to || resp_ct !== core_fn(a_pt, a_key)) begin
            n_bad++; $display("FAIL stab_ct: got %h want %h", resp_ct, core_fn(a_pt, a_key));
        end
        n_cmp++;
        if (pt_changes - base !== 0) begin
            n_bad++; $display("FAIL stab_busy_changes: got %0d want 0", pt_changes - base);
        end
        tick();
    endtask

    task automatic test_random();
        logic [N-1:0] rdy;
        logic [N-1:0] cur;
        bit to;
        int g;
        cur = '0;
        for (int it = 0; it < 12; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!cur[i] && $urandom_range(0, 1) == 1) begin
                    cur[i] = 1'b1;
                    pts[i] = rnd128();
                    keys[i] = rnd128();
                end
            end
            if (cur == '0) begin
                g = $urandom_range(0, N - 1);
                cur[g] = 1'b1;
                pts[g] = rnd128();
                keys[g] = rnd128();
            end
            apply_ops();
            req_valid = cur;
            core_lat = $urandom_range(1, 10);
            g = exp_grant(cur, exp_ptr);
            wait_grant(rdy, to);
            n_cmp++;
            if (rdy !== onehot(g)) begin
                n_bad++; $display("FAIL rand_grant%0d: got %b want %b", it, rdy, onehot(g));
            end
            tick();
            cur[g] = 1'b0;
            req_valid = cur;
            resp_ready = ($urandom_range(0, 1) == 1);
            wait_resp(to);
            if (!resp_ready) begin
                repeat ($urandom_range(0, 3)) tick();
            end
            n_cmp++;
            if (to || resp_id !== IW'(g) || resp_err !== 1'b0 ||
                resp_ct !== core_fn(pts[g], keys[g])) begin
                n_bad++; $display("FAIL rand_resp%0d: got id %0d err %b ct %h want id %0d ct %h",
                                  it, resp_id, resp_err, resp_ct, g, core_fn(pts[g], keys[g]));
            end
            resp_ready = 1'b1;
            exp_ptr = (g + 1) % N;
            if (it == 11) req_valid = '0;
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid_wait();
        logic [N-1:0] rdy;
        bit to;
        int base;
        pts[0] = rnd128();
        keys[0] = rnd128();
        pts[1] = rnd128();
        keys[1] = rnd128();
        apply_ops();
        core_lat = 12;
        req_valid = 3'b001;
        wait_grant(rdy, to);
        tick();
        req_valid = '0;
        repeat (4) tick();
        base = resp_cnt;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== '0 || resp_valid !== 1'b0 || core_encrypt !== 1'b0 ||
            resp_err !== 1'b0 || resp_id !== '0 || resp_ct !== '0 ||
            core_pt !== '0 || core_key !== '0) begin
            n_bad++; $display("FAIL midreset_zero: got valid %b pt %h want all zero", resp_valid, core_pt);
        end
        tick();
        tick();
        reset = 1'b0;
        exp_ptr = 0;
        repeat (15) tick();
        n_cmp++;
        if (resp_cnt - base !== 0 || resp_valid !== 1'b0) begin
            n_bad++; $display("FAIL midreset_late_done: got %0d responses want 0", resp_cnt - base);
        end
        req_valid = 3'b011;
        wait_grant(rdy, to);
        n_cmp++;
        if (rdy !== onehot(exp_grant(3'b011, exp_ptr))) begin
            n_bad++; $display("FAIL midreset_grant: got %b want 001", rdy);
        end
        tick();
        req_valid = '0;
        wait_resp(to);
        n_cmp++;
        if (to || resp_id !== 0 || resp_ct !== core_fn(pts[0], keys[0])) begin
            n_bad++; $display("FAIL midreset_resp: got id %0d ct %h want 0 %h", resp_id, resp_ct, core_fn(pts[0], keys[0]));
        end
        tick();
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0;
        req_pt = '0;
        req_key = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            pts[i] = '0;
            keys[i] = '0;
        end
        test_reset();
        test_fairness();
        test_single();
        test_backpressure();
        test_timeout();
        test_done_boundary();
        test_stability();
        test_random();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_enc_arbiter.md
Name: aes_enc_arbiter

Overview:
Round-robin scheduler that shares one iterative AES-128 encryption core (encrypt-start/done protocol) between N_REQ requesters. It accepts a plaintext/key pair from one requester, holds the operands stable at the core, pulses the core start, and waits for done. It then returns the ciphertext tagged with the requester ID on a valid/ready response channel. It sits between the system-side request ports and the encryption core's top level.

Parameters:
N_REQ, 2, number of requesters (2..8)
ID_W, 1, width of resp_id; must be at least ceil(log2(N_REQ))
TIMEOUT, 64, maximum cycles to wait for core_done before aborting (at least 16)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester accept; at most one bit high
req_pt  in  N_REQ*128  plaintexts; requester i occupies bits [128i+127:128i]
req_key  in  N_REQ*128  keys; same packing as req_pt
resp_valid  out  1  response valid
resp_ready  in  1  response accept
resp_id  out  ID_W  index of the requester served
resp_ct  out  128  ciphertext; zero when resp_err=1
resp_err  out  1  core timed out for this request
core_encrypt  out  1  one-cycle start pulse to the core
core_pt  out  128  registered plaintext to the core
core_key  out  128  registered key to the core
core_done  in  1  core completion
core_dout  in  128  core ciphertext

Behaviour:
- Reset (async, any state): state=IDLE, rr_ptr=0, req_ready=0, resp_valid=0, resp_err=0, resp_id=0, resp_ct=0, core_encrypt=0, core_pt=0, core_key=0, timeout counter=0. Reset mid-operation abandons the request with no response. A core_done arriving after reset release is ignored, because it arrives outside WAIT.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant goes to the first requester with req_valid=1, searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1 .. N_REQ-1, 0 ..).
  - req_ready[grant]=1 combinationally in IDLE only; all other bits are 0.
  - On that edge: capture req_pt/req_key of the grant into core_pt/core_key, capture the grant index into resp_id, set rr_ptr=(grant+1) mod N_REQ, and go to ISSUE.
  - No req_valid: stay in IDLE.
- ISSUE: core_encrypt=1 for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - core_done=1: capture core_dout into resp_ct, set resp_err=0, go to RESP.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 without done: resp_ct=0, resp_err=1, go to RESP.
  - core_done and the timeout in the same cycle: done wins.
- RESP:
  - resp_valid=1. resp_id, resp_ct and resp_err stay stable until resp_ready=1.
  - On resp_valid and resp_ready: next state is IDLE and resp_valid deasserts.
- core_pt and core_key hold from capture until the next accept; they never change while the core is busy.
- core_done seen in IDLE, ISSUE or RESP is ignored.
- Only one request is in flight at a time; there is no request queue.
- Minimum turnaround per request: 1 (accept) + 1 (ISSUE) + core latency + 1 (RESP with resp_ready already high).
- Requesters must hold req_valid and their operands stable until req_ready. A requester that drops req_valid before grant loses its turn with no side effect.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,N_REQ-1,0,...

Test Plan:
- Single request, requester 0: pt=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f, core model done after 12 cycles -> exactly one core_encrypt pulse; resp_ct=69c4e0d86a7b0430d8cdb78070b4c55a, resp_id=0, resp_err=0.
- Both requesters held valid for 4 requests, resp_ready tied high -> grant order 0,1,0,1; req_ready is never high for both requesters at once; resp_id sequence 0,1,0,1.
- Backpressure: resp_ready=0 for 20 cycles in RESP -> resp_valid/resp_id/resp_ct held constant; no new req_ready while resp_valid=1; release -> IDLE next cycle.
- Timeout: core model never asserts done -> RESP after TIMEOUT cycles in WAIT, resp_err=1, resp_ct=0. The next request then completes normally.
- Reset asserted mid-WAIT, then core_done pulses after release -> all outputs zero during reset; the late done produces no response; the next request is granted starting at requester 0.
- Operand stability: requester changes req_pt after being granted -> core_pt unchanged through WAIT; the ciphertext matches the originally captured plaintext.
